sa_clkgate_ctrl: RTL
====================

SA_CLKGATE_CTRL -- requirements
Module: sa_clkgate_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of gated clock channels (1..16).
REQ-002 SHALL have parameter CW, default 8, idle-hold counter width.
REQ-003 SHALL have parameter WAKE_CYC, default 2, clock-settle cycles before ready (1..15).
REQ-004 SHALL have port core_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port core_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port test_mode  input  1  scan/test override; forces every clk_en high.
REQ-007 SHALL have port cfg_gate_en  input  1  global gating enable; 0 = all channels treated as force-on.
REQ-008 SHALL have port cfg_force_on  input  NCH  per-channel keep-clock-on override.
REQ-009 SHALL have port cfg_idle_hold  input  CW  idle hysteresis count, sampled on IDLE entry.
REQ-010 SHALL have port req  input  NCH  per-channel wake request; level, held until ready seen.
REQ-011 SHALL have port busy  input  NCH  per-channel activity indication from the gated logic.
REQ-012 SHALL have port clk_en  output  NCH  enable to the E pin of each channel's clock-gate cell.
REQ-013 SHALL have port ready  output  NCH  channel clock stable; requester may issue work.
REQ-014 SHALL have port gated  output  NCH  channel clock currently off (state OFF).

Function
REQ-015 SHALL run one independent FSM per channel: OFF, WAKE, ON, IDLE.
REQ-016 SHALL define keep[i] = req[i] | busy[i] | cfg_force_on[i] | ~cfg_gate_en.
REQ-017 In OFF, SHALL go to WAKE when keep[i] = 1, loading wake counter with WAKE_CYC-1; else stay OFF.
REQ-018 In WAKE, SHALL decrement wake counter each cycle and go to ON on the edge where it equals 0; WAKE occupies exactly WAKE_CYC cycles, and keep[i] is ignored during WAKE.
REQ-019 In ON, SHALL stay while keep[i] = 1; else go to IDLE, loading idle counter with cfg_idle_hold.
REQ-020 In IDLE, SHALL return to ON if keep[i] = 1 (counter discarded); else go to OFF if counter = 0; else decrement; IDLE therefore lasts cfg_idle_hold+1 cycles when undisturbed.
REQ-021 SHALL register outputs from state: clk_en[i] = (state != OFF) | test_mode; ready[i] = state in {ON, IDLE}; gated[i] = (state == OFF).
REQ-022 test_mode SHALL affect clk_en only (combinational OR), never FSM state, ready or gated.
REQ-023 cfg_idle_hold = 0 SHALL give a single IDLE cycle before OFF; all-ones SHALL give 2^CW cycles, with no counter wrap.
REQ-024 Changes to cfg_idle_hold while in IDLE SHALL NOT affect the running count.
REQ-025 Channels SHALL NOT interact; simultaneous events on all channels SHALL be handled in the same cycle.
REQ-026 Deasserting cfg_gate_en SHALL wake every OFF channel via the normal WAKE path, never skipping WAKE.
REQ-027 clk_en SHALL be glitch-free: a flop output ORed with test_mode only.

Reset
REQ-028 On core_rst = 1 at a rising edge, every channel SHALL enter OFF with counters cleared: clk_en = test_mode replicated, ready = 0, gated = all ones.
REQ-029 Reset mid-WAKE/ON/IDLE SHALL force OFF on that edge with no intermediate state; the FSM resumes from OFF on the first edge after reset deasserts.

Verification (NCH=4, WAKE_CYC=2, cfg_idle_hold=3, cfg_gate_en=1, test_mode=0 unless stated; edge n = nth rising edge after stimulus cycle 0)
REQ-030 req[0] held cycle 0..2 then low, busy=0 -> clk_en[0] rises after edge 1, ready[0] after edge 3, IDLE at edge 4, clk_en[0]/ready[0] fall and gated[0] rises after edge 8; channels 1..3 stay gated.
REQ-031 Same as REQ-030 but busy[0] pulses one cycle during IDLE counter = 1 -> returns to ON; full 4-cycle IDLE restarts when busy drops; no clk_en drop.
REQ-032 cfg_idle_hold=0, single wake on channel 2 -> exactly one IDLE cycle, then OFF; cfg_idle_hold=255 -> exactly 256 IDLE cycles.
REQ-033 All four req asserted in the same cycle -> all clk_en rise on the same edge and all ready rise 2 edges later; cfg_gate_en=0 with req=0 -> all channels wake and remain ON.
REQ-034 core_rst asserted during WAKE on ch1 and IDLE on ch3 -> both OFF next edge, ready=0, gated=4'hF; with test_mode=1 clk_en=4'hF yet gated stays 4'hF.

Source files
------------

// File: rtl/sa_clkgate_ctrl.sv
// Per-channel clock-gate controller: each channel runs OFF -> WAKE -> ON -> IDLE
// and drives a flopped enable for its clock-gate cell, plus ready/gated status.
module sa_clkgate_ctrl #(
  parameter int NCH      = 4,
  parameter int CW       = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic           core_clk,
  input  logic           core_rst,
  input  logic           test_mode,
  input  logic           cfg_gate_en,
  input  logic [NCH-1:0] cfg_force_on,
  input  logic [CW-1:0]  cfg_idle_hold,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] busy,
  output logic [NCH-1:0] clk_en,
  output logic [NCH-1:0] ready,
  output logic [NCH-1:0] gated
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_e;

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYC - 1);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [CW-1:0] icnt_q, icnt_d;
    logic          en_q, rdy_q, gtd_q;
    logic          keep;

    assign keep = req[g] | busy[g] | cfg_force_on[g] | ~cfg_gate_en;

    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      icnt_d  = icnt_q;
      unique case (state_q)
        S_OFF: begin
          if (keep) begin
            state_d = S_WAKE;
            wcnt_d  = WAKE_LOAD;
          end
        end
        S_WAKE: begin
          // Settle time is fixed; keep is deliberately not consulted here.
          if (wcnt_q == 4'd0) begin
            state_d = S_ON;
          end else begin
            wcnt_d = wcnt_q - 4'd1;
          end
        end
        S_ON: begin
          if (!keep) begin
            state_d = S_IDLE;
            icnt_d  = cfg_idle_hold;
          end
        end
        S_IDLE: begin
          if (keep) begin
            state_d = S_ON;
          end else if (icnt_q == '0) begin
            state_d = S_OFF;
          end else begin
            icnt_d = icnt_q - 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // Status flops are loaded from next state so they match state_q exactly,
    // while clk_en comes from a single flop rather than a multi-bit decode.
    always_ff @(posedge core_clk) begin
      if (core_rst) begin
        state_q <= S_OFF;
        wcnt_q  <= '0;
        icnt_q  <= '0;
        en_q    <= 1'b0;
        rdy_q   <= 1'b0;
        gtd_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        icnt_q  <= icnt_d;
        en_q    <= (state_d != S_OFF);
        rdy_q   <= (state_d == S_ON) || (state_d == S_IDLE);
        gtd_q   <= (state_d == S_OFF);
      end
    end

    assign clk_en[g] = en_q | test_mode;
    assign ready[g]  = rdy_q;
    assign gated[g]  = gtd_q;
  end

endmodule
